// File: rtl/ptp_ts_queue_pkg.sv
// Shared definitions for the PTP timestamp queue: entry field widths and offsets,
// head-entry read word indices (also used by tsu_mx consumers) and helpers.
package ptp_ts_queue_pkg;

    localparam int unsigned TS_W    = 80;
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned SEQ_W   = 16;
    localparam int unsigned MTYPE_W = 4;
    localparam int unsigned SPI_W   = 80;
    localparam int unsigned ENTRY_W = TS_W + FRAC_W + SEQ_W + MTYPE_W + SPI_W;

    // Entry layout, LSB first: {spi, messageType, seqId, frac_ns, ts}
    localparam int unsigned TS_LSB    = 0;
    localparam int unsigned FRAC_LSB  = TS_LSB + TS_W;
    localparam int unsigned SEQ_LSB   = FRAC_LSB + FRAC_W;
    localparam int unsigned MTYPE_LSB = SEQ_LSB + SEQ_W;
    localparam int unsigned SPI_LSB   = MTYPE_LSB + MTYPE_W;

    localparam logic [2:0] RD_NS          = 3'd0;
    localparam logic [2:0] RD_SEC_LO      = 3'd1;
    localparam logic [2:0] RD_FRAC_SEC_HI = 3'd2;
    localparam logic [2:0] RD_SEQ_TYPE    = 3'd3;
    localparam logic [2:0] RD_SPI_LO      = 3'd4;
    localparam logic [2:0] RD_SPI_MID     = 3'd5;
    localparam logic [2:0] RD_SPI_HI      = 3'd6;
    localparam logic [2:0] RD_STATUS      = 3'd7;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [SPI_W-1:0]   spi,
        input logic [MTYPE_W-1:0] mtype,
        input logic [SEQ_W-1:0]   seq_id,
        input logic [FRAC_W-1:0]  frac_ns,
        input logic [TS_W-1:0]    ts
    );
        return {spi, mtype, seq_id, frac_ns, ts};
    endfunction

    function automatic logic [31:0] status_word(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [4:0] level
    );
        return {24'h0, ovf, full, empty, level};
    endfunction

endpackage

// File: rtl/ptp_ts_queue_if.sv
// Push/pop/control and status bundle of the PTP timestamp queue.
// The slave side is the queue itself; the master side is the TSU / CPU logic.
interface ptp_ts_queue_if;
    import ptp_ts_queue_pkg::*;

    logic                ts_push_i;
    logic [TS_W-1:0]     ts_i;
    logic [FRAC_W-1:0]   ts_frac_ns_i;
    logic [SEQ_W-1:0]    seqId_i;
    logic [MTYPE_W-1:0]  messageType_i;
    logic [SPI_W-1:0]    sourcePortIdentity_i;
    logic                pop_i;
    logic                flush_i;
    logic                clr_ovf_i;
    logic                int_en_i;
    logic [2:0]          rd_sel_i;
    logic [31:0]         rd_data_o;
    logic [4:0]          level_o;
    logic                empty_o;
    logic                full_o;
    logic                ovf_o;
    logic                int_o;

    modport master (
        output ts_push_i, ts_i, ts_frac_ns_i, seqId_i, messageType_i, sourcePortIdentity_i,
        output pop_i, flush_i, clr_ovf_i, int_en_i, rd_sel_i,
        input  rd_data_o, level_o, empty_o, full_o, ovf_o, int_o
    );

    modport slave (
        input  ts_push_i, ts_i, ts_frac_ns_i, seqId_i, messageType_i, sourcePortIdentity_i,
        input  pop_i, flush_i, clr_ovf_i, int_en_i, rd_sel_i,
        output rd_data_o, level_o, empty_o, full_o, ovf_o, int_o
    );

endinterface

// File: rtl/ptp_ts_queue_mem.sv
// Timestamp entry storage: DEPTH x ENTRY_W register array, one write port,
// one asynchronous read port. Contents are deliberately not reset.
module ptp_ts_queue_mem
    import ptp_ts_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Entry write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ptp_ts_queue.sv
// PTP timestamp queue: pointer, level, overflow and interrupt control plus the
// registered head-entry read mux; storage lives in ptp_ts_queue_mem.
module ptp_ts_queue
    import ptp_ts_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          rtc_clk,
    input  logic          rtc_rst_n,
    ptp_ts_queue_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]         level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               int_q, int_d;
    logic [31:0]        rd_data_q, rd_data_d, mux_s;
    logic               empty_s, full_s, do_push_s, do_pop_s, ovf_set_s, we_s;
    logic [ENTRY_W-1:0] entry_s, head_s;

    assign empty_s   = (level_q == 5'd0);
    assign full_s    = (level_q == 5'(DEPTH));
    assign do_pop_s  = bus.pop_i & ~empty_s;
    // A pop in the same cycle frees the slot a full queue needs for the push
    assign do_push_s = bus.ts_push_i & (~full_s | bus.pop_i);
    assign ovf_set_s = bus.ts_push_i & full_s & ~bus.pop_i;
    assign we_s      = do_push_s & ~bus.flush_i;
    assign int_d     = bus.int_en_i & ~empty_s;

    assign entry_s = pack_entry(bus.sourcePortIdentity_i, bus.messageType_i, bus.seqId_i,
                                bus.ts_frac_ns_i, bus.ts_i);

    ptp_ts_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (rtc_clk),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_s)
    );

    // Pointer, level and overflow next state; flush overrides everything else
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = 5'd0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            level_d = level_q + {4'd0, do_push_s} - {4'd0, do_pop_s};
            if (ovf_set_s) begin
                ovf_d = 1'b1;
            end else if (bus.clr_ovf_i) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Head-entry word select; entry words are masked while nothing is queued
    always_comb begin
        mux_s = 32'h0;
        case (bus.rd_sel_i)
            RD_NS:          mux_s = head_s[TS_LSB +: 32];
            RD_SEC_LO:      mux_s = head_s[TS_LSB + 32 +: 32];
            RD_FRAC_SEC_HI: mux_s = {head_s[FRAC_LSB +: FRAC_W], head_s[TS_LSB + 64 +: 16]};
            RD_SEQ_TYPE:    mux_s = {head_s[SEQ_LSB +: SEQ_W], 12'h0, head_s[MTYPE_LSB +: MTYPE_W]};
            RD_SPI_LO:      mux_s = head_s[SPI_LSB +: 32];
            RD_SPI_MID:     mux_s = head_s[SPI_LSB + 32 +: 32];
            RD_SPI_HI:      mux_s = {16'h0, head_s[SPI_LSB + 64 +: 16]};
            RD_STATUS:      mux_s = status_word(ovf_q, full_s, empty_s, level_q);
            default:        mux_s = 32'h0;
        endcase
        if (empty_s && (bus.rd_sel_i != RD_STATUS)) begin
            rd_data_d = 32'h0;
        end else begin
            rd_data_d = mux_s;
        end
    end

    // State and output registers
    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= 5'd0;
            ovf_q     <= 1'b0;
            int_q     <= 1'b0;
            rd_data_q <= 32'h0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            int_q     <= int_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.level_o   = level_q;
    assign bus.empty_o   = empty_s;
    assign bus.full_o    = full_s;
    assign bus.ovf_o     = ovf_q;
    assign bus.int_o     = int_q;

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Scoreboard bench for ptp_ts_queue (DEPTH=4): stimulus enqueues expected read
// words and status; a monitor compares them one cycle after each read request.
module tb_ptp_ts_queue;
    import ptp_ts_queue_pkg::*;

    typedef struct {
        string      name;
        logic [31:0] data;
        logic [4:0]  level;
        logic [3:0]  flags;   // {ovf, full, empty, int}
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rd_req = 1'b0;
    logic req_d  = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ptp_ts_queue_if bus();

    ptp_ts_queue #(.DEPTH(4)) dut (
        .rtc_clk   (clk),
        .rtc_rst_n (rst_n),
        .bus       (bus)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) req_d <= rd_req;

    always @(negedge clk) begin
        if (req_d) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got empty scoreboard, expected an entry");
            end else begin
                mon_e = sb.pop_front();
                cmp({mon_e.name, "/data"}, bus.rd_data_o, mon_e.data);
                cmp({mon_e.name, "/level"}, 32'(bus.level_o), 32'(mon_e.level));
                cmp({mon_e.name, "/flags"},
                    {28'h0, bus.ovf_o, bus.full_o, bus.empty_o, bus.int_o}, {28'h0, mon_e.flags});
            end
        end
    end

    task automatic check(input string name, input logic [2:0] sel, input logic [31:0] data,
                         input logic [4:0] lvl, input logic [3:0] fl);
        exp_t e;
        e.name = name; e.data = data; e.level = lvl; e.flags = fl;
        bus.rd_sel_i = sel;
        sb.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic op(input logic p, input logic pp, input logic f, input logic c);
        bus.ts_push_i = p;
        bus.pop_i     = pp;
        bus.flush_i   = f;
        bus.clr_ovf_i = c;
        @(negedge clk);
        bus.ts_push_i = 1'b0;
        bus.pop_i     = 1'b0;
        bus.flush_i   = 1'b0;
        bus.clr_ovf_i = 1'b0;
    endtask

    task automatic set_entry(input logic [15:0] seq);
        bus.seqId_i              = seq;
        bus.messageType_i        = 4'h1;
        bus.ts_i                 = {32'h0, seq, 32'h1000_0000};
        bus.ts_frac_ns_i         = ~seq;
        bus.sourcePortIdentity_i = {seq, 64'h0123_4567_89AB_CDEF};
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        bus.ts_push_i = 1'b0; bus.pop_i = 1'b0; bus.flush_i = 1'b0; bus.clr_ovf_i = 1'b0;
        bus.int_en_i = 1'b1; bus.rd_sel_i = 3'd0;
        set_entry(16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset", 3'd7, 32'h0000_0020, 5'd0, 4'b0010);

        // Single entry, all read words
        bus.ts_i = 80'h0000_0000_0005_1234_5678;
        bus.seqId_i = 16'h00A1;
        bus.messageType_i = 4'h0;
        bus.ts_frac_ns_i = 16'hBEEF;
        bus.sourcePortIdentity_i = 80'hAABB_CCDD_EEFF_0011_2233;
        op(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_ns",     3'd0, 32'h1234_5678, 5'd1, 4'b0001);
        check("t1_seq",    3'd3, 32'h00A1_0000, 5'd1, 4'b0001);
        check("t1_sec",    3'd1, 32'h0000_0005, 5'd1, 4'b0001);
        check("t1_frac",   3'd2, 32'hBEEF_0000, 5'd1, 4'b0001);
        check("t1_spi_lo", 3'd4, 32'h0011_2233, 5'd1, 4'b0001);
        check("t1_spi_md", 3'd5, 32'hCCDD_EEFF, 5'd1, 4'b0001);
        check("t1_spi_hi", 3'd6, 32'h0000_AABB, 5'd1, 4'b0001);
        check("t1_status", 3'd7, 32'h0000_0001, 5'd1, 4'b0001);
        op(1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_empty_ns", 3'd0, 32'h0, 5'd0, 4'b0010);

        // Overflow on fifth push, FIFO order on pops
        for (int n = 1; n <= 5; n++) begin
            set_entry(16'(n));
            op(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("t2_ovf_status", 3'd7, 32'h0000_00C4, 5'd4, 4'b1101);
        for (int n = 1; n <= 4; n++) begin
            check("t2_head", 3'd3, {16'(n), 16'h0001}, 5'(5 - n), {1'b1, (n == 1), 1'b0, 1'b1});
            op(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("t2_drained", 3'd7, 32'h0000_00A0, 5'd0, 4'b1010);
        op(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_clr_ovf", 3'd7, 32'h0000_0020, 5'd0, 4'b0010);

        // Push and pop together while full
        for (int n = 1; n <= 4; n++) begin
            set_entry(16'(n));
            op(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("t3_full", 3'd7, 32'h0000_0044, 5'd4, 4'b0101);
        set_entry(16'd5);
        op(1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_push_pop_full", 3'd7, 32'h0000_0044, 5'd4, 4'b0101);
        for (int n = 2; n <= 5; n++) begin
            check("t3_head", 3'd3, {16'(n), 16'h0001}, 5'(6 - n), {1'b0, (n == 2), 1'b0, 1'b1});
            op(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("t3_drained", 3'd7, 32'h0000_0020, 5'd0, 4'b0010);

        // Pop on empty, then push+pop on empty
        op(1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_pop_empty", 3'd7, 32'h0000_0020, 5'd0, 4'b0010);
        set_entry(16'h0077);
        op(1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_pp_head",   3'd3, 32'h0077_0001, 5'd1, 4'b0001);
        check("t4_pp_status", 3'd7, 32'h0000_0001, 5'd1, 4'b0001);
        op(1'b0, 1'b1, 1'b0, 1'b0);

        // Overflow beats clear; flush beats push
        for (int n = 1; n <= 4; n++) begin
            set_entry(16'(n));
            op(1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_entry(16'd9);
        op(1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_set_wins", 3'd7, 32'h0000_00C4, 5'd4, 4'b1101);
        check("t5_head",     3'd3, 32'h0001_0001, 5'd4, 4'b1101);
        set_entry(16'd10);
        op(1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_flush",    3'd7, 32'h0000_0020, 5'd0, 4'b0010);
        check("t5_flush_ns", 3'd0, 32'h0,         5'd0, 4'b0010);

        // Asynchronous reset with 3 entries queued and overflow set
        for (int n = 1; n <= 5; n++) begin
            set_entry(16'(n));
            op(1'b1, 1'b0, 1'b0, 1'b0);
        end
        op(1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_head", 3'd3, 32'h0002_0001, 5'd3, 4'b1001);
        drain();
        #2 rst_n = 1'b0;
        #1;
        cmp("t6_rst_data",  bus.rd_data_o, 32'h0);
        cmp("t6_rst_level", 32'(bus.level_o), 32'h0);
        cmp("t6_rst_flags", {28'h0, bus.ovf_o, bus.full_o, bus.empty_o, bus.int_o}, 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_after_reset", 3'd7, 32'h0000_0020, 5'd0, 4'b0010);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
